// File: rtl/regps_pkg.sv
// regps_pkg: shared widths and FSM state type for the shift-register sequencer
package regps_pkg;
    localparam int REG_W = 4;
    localparam int MAX_SHIFTS = REG_W;
    typedef enum logic [2:0] {IDLE, LOAD, SHIFT, SETTLE, CAPTURE, RESP} state_e;
endpackage

// File: rtl/regps_ctrl_if.sv
// regps_ctrl_if: host frame request (tx) and result response (rx) valid/ready channels
interface regps_ctrl_if;
    import regps_pkg::*;
    logic [REG_W-1:0] tx_data;
    logic [REG_W-1:0] si_data;
    logic             tx_valid;
    logic             tx_ready;
    logic [REG_W-1:0] rx_data;
    logic             rx_msb;
    logic             rx_valid;
    logic             rx_ready;
    modport master (
        output tx_data, si_data, tx_valid, rx_ready,
        input  tx_ready, rx_data, rx_msb, rx_valid
    );
    modport slave (
        input  tx_data, si_data, tx_valid, rx_ready,
        output tx_ready, rx_data, rx_msb, rx_valid
    );
endinterface

// File: rtl/regps_ctrl.sv
// regps_ctrl: loads a 4-bit shift register, shifts in SHIFTS bits MSB-first and returns its content.
// Optional REGPS_CTRL_COUNT_EN adds an 8-bit wrapping count of completed rx handshakes (frame_cnt).
module regps_ctrl
    import regps_pkg::*;
#(
    parameter int SHIFTS = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    regps_ctrl_if.slave      bus,
    output logic             reg_load,
    output logic             reg_shift_en,
    output logic             reg_shift_in,
    output logic [REG_W-1:0] reg_par_in,
    input  logic [REG_W-1:0] reg_content,
    input  logic             reg_shift_out
`ifdef REGPS_CTRL_COUNT_EN
    ,
    output logic [7:0]       frame_cnt
`endif
);
    if (SHIFTS < 0 || SHIFTS > MAX_SHIFTS) begin : g_bad_shifts
        $error("regps_ctrl: SHIFTS must lie in 0..4");
    end

    localparam logic [1:0] LAST = 2'(SHIFTS - 1);

    state_e           state_q, state_d;
    logic [REG_W-1:0] tx_q, tx_d, si_q, si_d, rx_data_q, rx_data_d;
    logic             rx_msb_q, rx_msb_d;
    logic [1:0]       cnt_q, cnt_d;

    // next-state and datapath capture for the frame sequence
    always_comb begin
        state_d   = state_q;
        tx_d      = tx_q;
        si_d      = si_q;
        cnt_d     = cnt_q;
        rx_data_d = rx_data_q;
        rx_msb_d  = rx_msb_q;
        case (state_q)
            IDLE: if (bus.tx_valid) begin
                state_d = LOAD;
                tx_d    = bus.tx_data;
                si_d    = bus.si_data;
            end
            LOAD: begin
                state_d = (SHIFTS == 0) ? SETTLE : SHIFT;
                cnt_d   = '0;
            end
            SHIFT: begin
                cnt_d   = cnt_q + 2'd1;
                state_d = (cnt_q == LAST) ? SETTLE : SHIFT;
            end
            SETTLE:  state_d = CAPTURE;
            CAPTURE: begin
                rx_data_d = reg_content;
                rx_msb_d  = reg_shift_out;
                state_d   = RESP;
            end
            RESP:    state_d = bus.rx_ready ? IDLE : RESP;
            default: state_d = IDLE;
        endcase
    end

    // state and datapath registers; reset discards any in-flight frame
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            tx_q      <= '0;
            si_q      <= '0;
            cnt_q     <= '0;
            rx_data_q <= '0;
            rx_msb_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            tx_q      <= tx_d;
            si_q      <= si_d;
            cnt_q     <= cnt_d;
            rx_data_q <= rx_data_d;
            rx_msb_q  <= rx_msb_d;
        end
    end

    assign reg_load     = (state_q == LOAD);
    assign reg_shift_en = (state_q == SHIFT);
    assign reg_shift_in = reg_shift_en & si_q[2'd3 - cnt_q];
    assign reg_par_in   = tx_q;
    assign bus.tx_ready = (state_q == IDLE);
    assign bus.rx_valid = (state_q == RESP);
    assign bus.rx_data  = rx_data_q;
    assign bus.rx_msb   = rx_msb_q;

`ifdef REGPS_CTRL_COUNT_EN
    logic [7:0] frame_cnt_q, frame_cnt_d;

    // count completed result handshakes, wrapping at 256
    always_comb frame_cnt_d = frame_cnt_q + 8'(bus.rx_valid & bus.rx_ready);

    // frame counter register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) frame_cnt_q <= '0;
        else frame_cnt_q <= frame_cnt_d;
    end

    assign frame_cnt = frame_cnt_q;
`endif
endmodule
